ser_tx: RTL and testbench
=========================

SER_TX -- requirements
Module: ser_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame (legal range 1..16).
REQ-002 SHALL have parameter DIV, default 4, clock cycles per serial bit (legal range 1..256).
REQ-003 SHALL have port clk_i  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port data_i  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port valid_i  input  1  data_i is valid.
REQ-007 SHALL have port ready_o  output  1  block accepts a word this cycle.
REQ-008 SHALL have port ser_o  output  1  serial line, idle high.
REQ-009 SHALL have port busy_o  output  1  a frame is in progress.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse on the final cycle of a frame.

Function
REQ-011 SHALL accept a word when valid_i and ready_o are both high at a rising clk_i edge, capturing data_i into a WIDTH-bit holding/shift register.
REQ-012 SHALL drive ready_o high only in state IDLE, combinationally from state; valid_i in any other state is ignored.
REQ-013 SHALL implement states IDLE, START, DATA, STOP: IDLE->START on accept; START->DATA after DIV cycles; DATA->STOP after WIDTH*DIV cycles; STOP->IDLE after DIV cycles.
REQ-014 SHALL drive ser_o: 1 in IDLE; 0 in START; the current shift-register LSB in DATA; 1 in STOP.
REQ-015 SHALL shift the holding register right by one at the end of every DIV-cycle bit period in DATA, so data goes out LSB first.
REQ-016 SHALL implement the bit-period counter with width $clog2(DIV+1). It SHALL count 0..DIV-1 and wrap to 0 on every bit boundary.
REQ-017 SHALL count data bits with a bit index of width $clog2(WIDTH+1), cleared on entry to DATA.
REQ-018 SHALL make each frame occupy exactly (WIDTH+2)*DIV cycles from the cycle after acceptance.
REQ-019 SHALL not pipeline back-to-back frames: ready_o reasserts in the first cycle after STOP, so the minimum accept-to-accept period is (WIDTH+2)*DIV+1 cycles.
REQ-020 SHALL drive busy_o high in START, DATA and STOP, and low in IDLE.
REQ-021 SHALL assert done_o for exactly the last clock cycle of STOP.
REQ-022 SHALL, for DIV=1, advance one bit per cycle with no extra wait cycles.
REQ-023 SHALL have ser_o and done_o be free of glitches, either registered or decoded from registered state only.

Reset
REQ-024 SHALL on rst_ni low, immediately and asynchronously force state IDLE, clear both counters and the shift register, and drive ser_o=1, busy_o=0, done_o=0, ready_o=1 after release.
REQ-025 SHALL treat reset asserted mid-frame as an abort: the line returns high at once, no done_o is produced, and the partial word is discarded.
REQ-026 SHALL accept a new word on the first rising edge after rst_ni deasserts if valid_i is high.

Structure
REQ-027 SHALL place the state typedef (ser_tx_state_e: IDLE, START, DATA, STOP) in package ser_tx_pkg.
REQ-028 SHALL contain one sub-module ser_tx_baud: the DIV-cycle bit-period counter with clear input and a bit-tick output, asynchronously reset on rst_ni.
REQ-029 SHALL keep the holding/shift register and FSM in ser_tx itself; the design SHALL map onto the team's existing discrete flip-flop, mux and gate cells without latches.

Verification
REQ-030 SHALL cover WIDTH=8, DIV=4, send 0xA5 -> ser_o = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done_o pulses on cycle 40 after accept.
REQ-031 SHALL cover valid_i held high with words 0x00 then 0xFF -> second accept occurs exactly 41 cycles after the first; ready_o stays low in between.
REQ-032 SHALL cover rst_ni pulsed low at cycle 17 of a 0x3C frame -> ser_o=1 and busy_o=0 in the same cycle, with no done_o afterwards.
REQ-033 SHALL cover WIDTH=8, DIV=1, send 0x81 -> ser_o = 0,1,0,0,0,0,0,0,1,1 on consecutive cycles; done_o on cycle 10.
REQ-034 SHALL cover valid_i toggled during busy_o with a different word -> the transmitted frame is unchanged and no extra accept occurs.
REQ-035 SHALL cover WIDTH=1, DIV=256, send 1 -> a 768-cycle frame in which the counter wrap is exercised with no off-by-one.

Source files
------------

// File: rtl/ser_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ser_tx_pkg
// Purpose  : Shared types and helpers for the ser_tx serial transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package ser_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ser_tx_state_e;

    // Clock cycles one frame occupies, start bit through stop bit.
    function automatic int frame_cycles(input int width, input int div);
        return (width + 2) * div;
    endfunction

endpackage : ser_tx_pkg
`default_nettype wire

// File: rtl/ser_tx_baud.sv
`default_nettype none
// ============================================================================
// Module   : ser_tx_baud
// Purpose  : Bit-period counter; pulses tick_o on the last cycle of each bit.
// Revision : 1.0 - initial release
// ============================================================================
module ser_tx_baud #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int               C_CNT_W = $clog2(DIV + 1);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(DIV - 1);
    localparam logic [C_CNT_W-1:0] C_ONE  = C_CNT_W'(1);

    logic [C_CNT_W-1:0] cnt_q;
    logic [C_CNT_W-1:0] cnt_d;
    logic               w_tick;

    assign w_tick = !clr_i && (cnt_q == C_LAST);
    assign tick_o = w_tick;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || w_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + C_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : ser_tx_baud
`default_nettype wire

// File: rtl/ser_tx.sv
`default_nettype none
// ============================================================================
// Module   : ser_tx
// Purpose  : Parallel-to-serial transmitter: start bit, WIDTH data bits LSB
//            first, stop bit, each bit held for DIV clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
module ser_tx
    import ser_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             ser_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int            C_BIT_W    = $clog2(WIDTH + 1);
    localparam logic [C_BIT_W-1:0] C_LAST_BIT = C_BIT_W'(WIDTH - 1);
    localparam logic [C_BIT_W-1:0] C_BIT_ONE  = C_BIT_W'(1);

    ser_tx_state_e      state_q;
    ser_tx_state_e      state_d;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   shreg_d;
    logic [C_BIT_W-1:0] bit_q;
    logic [C_BIT_W-1:0] bit_d;

    logic               w_tick;
    logic               w_baud_clr;
    logic [WIDTH-1:0]   w_shifted;

    // Counter is held clear while idle so the START bit gets a full period.
    assign w_baud_clr = (state_q == IDLE);

    ser_tx_baud #(
        .DIV (DIV)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (w_baud_clr),
        .tick_o (w_tick)
    );

    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_shifted = 1'b0;
        end else begin : g_shift_wn
            assign w_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    shreg_d = data_i;
                    state_d = START;
                end
            end
            START: begin
                if (w_tick) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    shreg_d = w_shifted;
                    bit_d   = bit_q + C_BIT_ONE;
                    if (bit_q == C_LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
        end
    end

    // Outputs decode registered state only, so they cannot glitch on inputs.
    always_comb begin
        ser_o = 1'b1;
        case (state_q)
            IDLE:    ser_o = 1'b1;
            START:   ser_o = 1'b0;
            DATA:    ser_o = shreg_q[0];
            STOP:    ser_o = 1'b1;
            default: ser_o = 1'b1;
        endcase
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == STOP) && w_tick;

endmodule : ser_tx
`default_nettype wire

// File: tb/tb_ser_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ser_tx
// Purpose  : Scoreboard bench for ser_tx across three WIDTH/DIV configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ser_tx;

    localparam int NI      = 3;
    localparam int WS [NI] = '{8, 8, 1};
    localparam int DS [NI] = '{4, 1, 256};
    localparam int BOUND   = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n [NI];
    logic       valid [NI];
    logic       ready [NI];
    logic       ser   [NI];
    logic       busy  [NI];
    logic       done  [NI];
    logic [7:0] data0;
    logic [7:0] data1;
    logic [0:0] data2;

    int n_vec = 0;
    int n_err = 0;
    int acc_n   [NI];
    int exp_acc [NI];

    // Each entry is {done expected, ser expected} for one busy cycle.
    logic [1:0] q0 [$];
    logic [1:0] q1 [$];
    logic [1:0] q2 [$];

    ser_tx #(.WIDTH(WS[0]), .DIV(DS[0])) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .data_i(data0), .valid_i(valid[0]),
        .ready_o(ready[0]), .ser_o(ser[0]), .busy_o(busy[0]), .done_o(done[0]));
    ser_tx #(.WIDTH(WS[1]), .DIV(DS[1])) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .data_i(data1), .valid_i(valid[1]),
        .ready_o(ready[1]), .ser_o(ser[1]), .busy_o(busy[1]), .done_o(done[1]));
    ser_tx #(.WIDTH(WS[2]), .DIV(DS[2])) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n[2]), .data_i(data2), .valid_i(valid[2]),
        .ready_o(ready[2]), .ser_o(ser[2]), .busy_o(busy[2]), .done_o(done[2]));

    task automatic chk(input string nm, input int i, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d @%0t: got %0d, expected %0d", nm, i, $time, got, exp);
        end
    endtask

    task automatic mon_cycle(input int i, input bit have, input logic [1:0] e);
        if (busy[i]) begin
            chk("ready_while_busy", i, 64'(ready[i]), 64'd0);
            if (!have) begin
                chk("unexpected_busy", i, 64'd1, 64'd0);
            end else begin
                chk("ser_o", i, 64'(ser[i]), 64'(e[0]));
                chk("done_o", i, 64'(done[i]), 64'(e[1]));
            end
        end else begin
            chk("idle_ser", i, 64'(ser[i]), 64'd1);
            chk("idle_done", i, 64'(done[i]), 64'd0);
        end
        if (valid[i] && ready[i]) acc_n[i]++;
    endtask

    always @(negedge clk) begin : m0
        logic [1:0] e;
        bit h;
        e = '0; h = 1'b0;
        if (rst_n[0]) begin
            if (busy[0] && q0.size() > 0) begin e = q0.pop_front(); h = 1'b1; end
            mon_cycle(0, h, e);
        end
    end

    always @(negedge clk) begin : m1
        logic [1:0] e;
        bit h;
        e = '0; h = 1'b0;
        if (rst_n[1]) begin
            if (busy[1] && q1.size() > 0) begin e = q1.pop_front(); h = 1'b1; end
            mon_cycle(1, h, e);
        end
    end

    always @(negedge clk) begin : m2
        logic [1:0] e;
        bit h;
        e = '0; h = 1'b0;
        if (rst_n[2]) begin
            if (busy[2] && q2.size() > 0) begin e = q2.pop_front(); h = 1'b1; end
            mon_cycle(2, h, e);
        end
    end

    // Expands a hand-written frame (bit 0 = start bit) into per-cycle entries.
    task automatic push_frame(input int i, input logic [17:0] frame);
        logic [1:0] e;
        for (int b = 0; b < WS[i] + 2; b++) begin
            for (int k = 0; k < DS[i]; k++) begin
                e = {(b == WS[i] + 1) && (k == DS[i] - 1), frame[b]};
                case (i)
                    0:       q0.push_back(e);
                    1:       q1.push_back(e);
                    default: q2.push_back(e);
                endcase
            end
        end
    endtask

    task automatic send(input int i, input logic [15:0] w, input logic [17:0] frame,
                        input bit keep, output time t);
        int n;
        valid[i] = 1'b1;
        case (i)
            0:       data0 = w[7:0];
            1:       data1 = w[7:0];
            default: data2 = w[0:0];
        endcase
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready[i] && n < BOUND);
        if (!ready[i]) begin
            chk("accept_timeout", i, 64'd0, 64'd1);
            valid[i] = 1'b0;
            t = 0;
            return;
        end
        push_frame(i, frame);
        exp_acc[i]++;
        @(posedge clk);
        t = $time;
        #1;
        if (!keep) valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy[i] && n < BOUND);
        if (busy[i]) chk("idle_timeout", i, 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        time t, t1, t2, t_rel;
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b0; valid[i] = 1'b0; acc_n[i] = 0; exp_acc[i] = 0;
        end
        data0 = '0; data1 = '0; data2 = '0;

        #3;
        for (int i = 0; i < NI; i++) begin
            chk("rst_ser", i, 64'(ser[i]), 64'd1);
            chk("rst_busy", i, 64'(busy[i]), 64'd0);
            chk("rst_done", i, 64'(done[i]), 64'd0);
            chk("rst_ready", i, 64'(ready[i]), 64'd1);
        end
        @(posedge clk); @(posedge clk); #2;
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
        @(posedge clk); #1;

        // WIDTH=8 DIV=4: single word 0xA5
        send(0, 16'hA5, 18'h34A, 1'b0, t);
        wait_idle(0);

        // Back-to-back with valid held high: 0x00 then 0xFF
        send(0, 16'h00, 18'h200, 1'b1, t1);
        send(0, 16'hFF, 18'h3FE, 1'b0, t2);
        chk("b2b_period_8x4", 0, 64'((t2 - t1) / 10), 64'd41);
        wait_idle(0);

        // valid toggled with another word while busy
        send(0, 16'h96, 18'h32C, 1'b0, t);
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            valid[0] = ~valid[0];
            data0 = 8'h11;
        end
        valid[0] = 1'b0;
        wait_idle(0);

        // Reset abort in cycle 17 of a 0x3C frame, then accept right after release
        send(0, 16'h3C, 18'h278, 1'b0, t);
        repeat (16) @(posedge clk);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("abort_ser", 0, 64'(ser[0]), 64'd1);
        chk("abort_busy", 0, 64'(busy[0]), 64'd0);
        chk("abort_done", 0, 64'(done[0]), 64'd0);
        chk("abort_ready", 0, 64'(ready[0]), 64'd1);
        q0.delete();
        valid[0] = 1'b1;
        data0 = 8'h55;
        @(posedge clk); @(posedge clk); #2;
        rst_n[0] = 1'b1;
        t_rel = $time;
        send(0, 16'h55, 18'h2AA, 1'b0, t);
        chk("accept_after_reset", 0, 64'(t - t_rel), 64'd8);
        wait_idle(0);

        // WIDTH=8 DIV=1
        send(1, 16'h81, 18'h302, 1'b0, t);
        wait_idle(1);
        send(1, 16'h3C, 18'h278, 1'b1, t1);
        send(1, 16'hC3, 18'h386, 1'b0, t2);
        chk("b2b_period_8x1", 1, 64'((t2 - t1) / 10), 64'd11);
        wait_idle(1);

        // WIDTH=1 DIV=256
        send(2, 16'h1, 18'b110, 1'b1, t1);
        send(2, 16'h0, 18'b100, 1'b0, t2);
        chk("b2b_period_1x256", 2, 64'((t2 - t1) / 10), 64'd769);
        wait_idle(2);

        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("accept_count", i, 64'(acc_n[i]), 64'(exp_acc[i]));
        end
        chk("pending_q0", 0, 64'(q0.size()), 64'd0);
        chk("pending_q1", 1, 64'(q1.size()), 64'd0);
        chk("pending_q2", 2, 64'(q2.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ser_tx
`default_nettype wire
